// File: rtl/ram_interface_scalar_mul_pkg.sv
// Shared constants for the scalar-multiplier host RAM interface: bus sizes,
// register map and command codes.
package ram_interface_scalar_mul_pkg;

   localparam int unsigned DATA_MSB  = 255;
   localparam int unsigned ADDR_MSB  = 5;

   localparam int unsigned CMD_ADDR  = 'h00;
   localparam int unsigned STAT_ADDR = 'h01;
   localparam int unsigned RAM_BASE  = 'h02;

   localparam int unsigned CMD_IDLE  = 0;
   localparam int unsigned CMD_START = 2;

endpackage

// File: rtl/ram_interface_scalar_mul_if.sv
// Host (port A) and engine (port B) bus bundle for the scalar-multiplier RAM.
interface ram_interface_scalar_mul_if
   import ram_interface_scalar_mul_pkg::*;
#(
   parameter int unsigned Data = DATA_MSB,
   parameter int unsigned Addr = ADDR_MSB
);

   logic          a_w;
   logic [Addr:0] a_adbus;
   logic [Data:0] a_data_in;
   logic [Data:0] a_data_out;
   logic          b_w;
   logic [Addr:0] b_adbus;
   logic [Data:0] b_data_in;
   logic [Data:0] b_data_out;
   logic [Data:0] command;
   logic [Data:0] status;

   modport master (
      output a_w, a_adbus, a_data_in, b_w, b_adbus, b_data_in, status,
      input  a_data_out, b_data_out, command
   );

   modport slave (
      input  a_w, a_adbus, a_data_in, b_w, b_adbus, b_data_in, status,
      output a_data_out, b_data_out, command
   );

endinterface

// File: rtl/dpram_64x256.sv
// Dual-port word array: two synchronous write ports, two asynchronous read
// ports; port A wins when both write the same word.
module dpram_64x256
   import ram_interface_scalar_mul_pkg::*;
#(
   parameter int unsigned Data = DATA_MSB,
   parameter int unsigned Addr = ADDR_MSB
) (
   input  logic          clk,
   input  logic          a_we,
   input  logic [Addr:0] a_addr,
   input  logic [Data:0] a_wdata,
   output logic [Data:0] a_rdata,
   input  logic          b_we,
   input  logic [Addr:0] b_addr,
   input  logic [Data:0] b_wdata,
   output logic [Data:0] b_rdata
);

   logic [Data:0] mem [2**(Addr+1)];

   // Port A is written last so it overrides port B on an address collision.
   always_ff @(posedge clk) begin
      if (b_we) mem[b_addr] <= b_wdata;
      if (a_we) mem[a_addr] <= a_wdata;
   end

   assign a_rdata = mem[a_addr];
   assign b_rdata = mem[b_addr];

endmodule

// File: rtl/ram_interface_scalar_mul.sv
// Host/engine shared RAM with a one-cycle pulsed command register at 0x00 and
// a free-running status capture register at 0x01.
module ram_interface_scalar_mul
   import ram_interface_scalar_mul_pkg::*;
#(
   parameter int unsigned Data = DATA_MSB,
   parameter int unsigned Addr = ADDR_MSB
) (
   input logic                      clk,
   input logic                      rst_n,
   ram_interface_scalar_mul_if.slave bus
);

   localparam logic [Addr:0] CmdAddr  = (Addr+1)'(CMD_ADDR);
   localparam logic [Addr:0] StatAddr = (Addr+1)'(STAT_ADDR);
   localparam logic [Addr:0] RamBase  = (Addr+1)'(RAM_BASE);

   logic [Data:0] cmd_q, cmd_d;
   logic [Data:0] stat_q;
   logic [Data:0] ram_a_rdata, ram_b_rdata;
   logic          ram_a_we, ram_b_we;

   always_comb begin
      ram_a_we = rst_n && bus.a_w && (bus.a_adbus >= RamBase);
      ram_b_we = rst_n && bus.b_w && (bus.b_adbus >= RamBase);
      // The command self-clears unless the host reloads it this cycle.
      cmd_d = (Data+1)'(CMD_IDLE);
      if (bus.a_w && (bus.a_adbus == CmdAddr)) cmd_d = bus.a_data_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_q  <= '0;
         stat_q <= '0;
      end else begin
         cmd_q  <= cmd_d;
         stat_q <= bus.status;
      end
   end

   dpram_64x256 #(
      .Data (Data),
      .Addr (Addr)
   ) u_dpram (
      .clk     (clk),
      .a_we    (ram_a_we),
      .a_addr  (bus.a_adbus),
      .a_wdata (bus.a_data_in),
      .a_rdata (ram_a_rdata),
      .b_we    (ram_b_we),
      .b_addr  (bus.b_adbus),
      .b_wdata (bus.b_data_in),
      .b_rdata (ram_b_rdata)
   );

   always_comb begin
      bus.command = cmd_q;
      if (bus.a_adbus == CmdAddr)       bus.a_data_out = cmd_q;
      else if (bus.a_adbus == StatAddr) bus.a_data_out = stat_q;
      else                              bus.a_data_out = ram_a_rdata;
      if (bus.b_adbus == CmdAddr)       bus.b_data_out = cmd_q;
      else if (bus.b_adbus == StatAddr) bus.b_data_out = stat_q;
      else                              bus.b_data_out = ram_b_rdata;
   end

endmodule

// File: tb/tb_ram_interface_scalar_mul.sv
// Directed self-checking bench for ram_interface_scalar_mul.
module tb_ram_interface_scalar_mul;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   ram_interface_scalar_mul_if #(.Data(255), .Addr(5)) bus ();

   ram_interface_scalar_mul #(.Data(255), .Addr(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs are changed and outputs sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.a_w = 1'b0;
      bus.b_w = 1'b0;
      bus.a_data_in = '0;
      bus.b_data_in = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      bus.a_adbus = 6'h00;
      bus.b_adbus = 6'h01;
      bus.status = '0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      tests++;
      if (bus.command !== 256'h0) begin
         fails++; $display("FAIL reset_command got %0h want 0", bus.command);
      end
      tests++;
      if (bus.a_data_out !== 256'h0) begin
         fails++; $display("FAIL reset_cmd_read got %0h want 0", bus.a_data_out);
      end
      tests++;
      if (bus.b_data_out !== 256'h0) begin
         fails++; $display("FAIL reset_stat_read got %0h want 0", bus.b_data_out);
      end
   endtask

   task automatic test_ram_rw();
      bus.a_w = 1'b1; bus.a_adbus = 6'h15; bus.a_data_in = 256'hABCD;
      tick();
      idle();
      bus.b_adbus = 6'h15;
      #1;
      tests++;
      if (bus.b_data_out !== 256'hABCD) begin
         fails++; $display("FAIL ram_b_read got %0h want abcd", bus.b_data_out);
      end
      tests++;
      if (bus.a_data_out !== 256'hABCD) begin
         fails++; $display("FAIL ram_a_read got %0h want abcd", bus.a_data_out);
      end
      // Top word of the map.
      bus.b_w = 1'b1; bus.b_adbus = 6'h3F; bus.b_data_in = {4'hF, 252'h1234};
      tick();
      idle();
      bus.a_adbus = 6'h3F;
      #1;
      tests++;
      if (bus.a_data_out !== {4'hF, 252'h1234}) begin
         fails++; $display("FAIL ram_top_word got %0h want f..1234", bus.a_data_out);
      end
   endtask

   task automatic test_cmd_pulse();
      bus.a_w = 1'b1; bus.a_adbus = 6'h00; bus.a_data_in = 256'h2;
      #1;
      tests++;
      if (bus.command !== 256'h0) begin
         fails++; $display("FAIL cmd_before_edge got %0h want 0", bus.command);
      end
      tick();
      idle();
      bus.b_adbus = 6'h00;
      #1;
      tests++;
      if (bus.command !== 256'h2) begin
         fails++; $display("FAIL cmd_pulse got %0h want 2", bus.command);
      end
      tests++;
      if (bus.b_data_out !== 256'h2) begin
         fails++; $display("FAIL cmd_b_read got %0h want 2", bus.b_data_out);
      end
      tick();
      tests++;
      if (bus.command !== 256'h0) begin
         fails++; $display("FAIL cmd_clear got %0h want 0", bus.command);
      end
      tests++;
      if (bus.a_data_out !== 256'h0) begin
         fails++; $display("FAIL cmd_a_read_after got %0h want 0", bus.a_data_out);
      end
      // Reload on consecutive cycles keeps the register live.
      bus.a_w = 1'b1; bus.a_data_in = 256'h2;
      tick();
      bus.a_data_in = 256'h3;
      tick();
      idle();
      tests++;
      if (bus.command !== 256'h3) begin
         fails++; $display("FAIL cmd_reload got %0h want 3", bus.command);
      end
      tick();
      tests++;
      if (bus.command !== 256'h0) begin
         fails++; $display("FAIL cmd_reload_clear got %0h want 0", bus.command);
      end
   endtask

   task automatic test_status();
      bus.status = 256'h5;
      bus.a_adbus = 6'h01;
      bus.b_adbus = 6'h01;
      #1;
      tests++;
      if (bus.a_data_out !== 256'h0) begin
         fails++; $display("FAIL stat_latency got %0h want 0", bus.a_data_out);
      end
      tick();
      tests++;
      if (bus.a_data_out !== 256'h5) begin
         fails++; $display("FAIL stat_a_read got %0h want 5", bus.a_data_out);
      end
      tests++;
      if (bus.b_data_out !== 256'h5) begin
         fails++; $display("FAIL stat_b_read got %0h want 5", bus.b_data_out);
      end
      bus.a_w = 1'b1; bus.a_data_in = 256'hFF;
      bus.b_w = 1'b1; bus.b_data_in = 256'hEE;
      tick();
      idle();
      tests++;
      if (bus.a_data_out !== 256'h5) begin
         fails++; $display("FAIL stat_write_ignored got %0h want 5", bus.a_data_out);
      end
      bus.b_w = 1'b1; bus.b_adbus = 6'h00; bus.b_data_in = 256'h7;
      tick();
      idle();
      tests++;
      if (bus.command !== 256'h0) begin
         fails++; $display("FAIL cmd_b_write_ignored got %0h want 0", bus.command);
      end
   endtask

   task automatic test_back_to_back();
      bus.a_w = 1'b1; bus.a_adbus = 6'h20; bus.a_data_in = 256'h1;
      bus.b_w = 1'b1; bus.b_adbus = 6'h20; bus.b_data_in = 256'h2;
      tick();
      idle();
      bus.b_adbus = 6'h20;
      #1;
      tests++;
      if (bus.b_data_out !== 256'h1) begin
         fails++; $display("FAIL collision_a_wins got %0h want 1", bus.b_data_out);
      end
      bus.a_w = 1'b1; bus.a_adbus = 6'h21; bus.a_data_in = 256'h11;
      bus.b_w = 1'b1; bus.b_adbus = 6'h22; bus.b_data_in = 256'h22;
      tick();
      idle();
      #1;
      tests++;
      if (bus.a_data_out !== 256'h11) begin
         fails++; $display("FAIL dual_write_a got %0h want 11", bus.a_data_out);
      end
      tests++;
      if (bus.b_data_out !== 256'h22) begin
         fails++; $display("FAIL dual_write_b got %0h want 22", bus.b_data_out);
      end
   endtask

   task automatic test_read_during_write();
      bus.a_w = 1'b1; bus.a_adbus = 6'h30; bus.a_data_in = 256'h7;
      tick();
      bus.a_data_in = 256'h9;
      bus.b_adbus = 6'h30;
      #1;
      tests++;
      if (bus.b_data_out !== 256'h7) begin
         fails++; $display("FAIL rdw_old got %0h want 7", bus.b_data_out);
      end
      tick();
      idle();
      #1;
      tests++;
      if (bus.b_data_out !== 256'h9) begin
         fails++; $display("FAIL rdw_new got %0h want 9", bus.b_data_out);
      end
   endtask

   task automatic test_reset_mid_pulse();
      bus.a_w = 1'b1; bus.a_adbus = 6'h00; bus.a_data_in = 256'h2;
      tick();
      idle();
      tests++;
      if (bus.command !== 256'h2) begin
         fails++; $display("FAIL mid_pulse_set got %0h want 2", bus.command);
      end
      // Writes attempted while reset is asserted must be dropped.
      rst_n = 1'b0;
      bus.a_w = 1'b1; bus.a_adbus = 6'h15; bus.a_data_in = 256'hDEAD;
      bus.b_w = 1'b1; bus.b_adbus = 6'h15; bus.b_data_in = 256'hBEEF;
      tick();
      idle();
      bus.a_adbus = 6'h01;
      #1;
      tests++;
      if (bus.command !== 256'h0) begin
         fails++; $display("FAIL mid_pulse_reset got %0h want 0", bus.command);
      end
      tests++;
      if (bus.a_data_out !== 256'h0) begin
         fails++; $display("FAIL reset_stat_clear got %0h want 0", bus.a_data_out);
      end
      tests++;
      if (bus.b_data_out !== 256'hABCD) begin
         fails++; $display("FAIL ram_kept_in_reset got %0h want abcd", bus.b_data_out);
      end
      rst_n = 1'b1;
      tick();
      tests++;
      if (bus.a_data_out !== 256'h5) begin
         fails++; $display("FAIL stat_after_reset got %0h want 5", bus.a_data_out);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_ram_rw();
      test_cmd_pulse();
      test_status();
      test_back_to_back();
      test_read_during_write();
      test_reset_mid_pulse();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ram_interface_scalar_mul.md
RAM_INTERFACE_SCALAR_MUL -- requirements
Module: ram_interface_scalar_mul

Interface
REQ-001 The block SHALL have parameter Data, default 255: MSB index of every data bus, so buses are Data+1 = 256 bits wide.
REQ-002 The block SHALL have parameter Addr, default 5: MSB index of every address bus, giving 64 words.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 Port a_w, input, 1 bit: port A (host side) write enable.
REQ-007 Port a_adbus, input, Addr+1 bits: port A address.
REQ-008 Port a_data_in, input, Data+1 bits: port A write data.
REQ-009 Port a_data_out, output, Data+1 bits: port A read data.
REQ-010 Port b_w, input, 1 bit: port B (engine side) write enable.
REQ-011 Port b_adbus, input, Addr+1 bits: port B address.
REQ-012 Port b_data_in, input, Data+1 bits: port B write data.
REQ-013 Port b_data_out, output, Data+1 bits: port B read data.
REQ-014 Port command, output, Data+1 bits: current command register value.
REQ-015 Port status, input, Data+1 bits: engine status word, captured into the status register.

Function
REQ-016 Memory map SHALL be: 0x00 = command register (CMD); 0x01 = status register (STAT); 0x02..0x3F = 62 general 256-bit RAM words shared by both ports.
REQ-017 Reads on both ports SHALL be combinational: a_data_out and b_data_out reflect the word at the current address in the same cycle, with no clock latency.
REQ-018 A read of an address being written in the same cycle SHALL return the pre-write value; the new value is visible from the next cycle.
REQ-019 A port A write (a_w=1) SHALL update the addressed word at the clock edge; for 0x00 this loads CMD.
REQ-020 CMD SHALL be a pulse register: after a load, CMD holds the written value for exactly one cycle and then clears to 0 at the next edge, unless port A writes 0x00 again in that cycle.
REQ-021 command SHALL equal CMD at all times.
REQ-022 STAT SHALL load the status input every cycle.
REQ-023 Port A writes to 0x01 SHALL be ignored.
REQ-024 A read of 0x01 on either port SHALL return STAT, i.e. status delayed by one cycle.
REQ-025 Port B writes to 0x00 and 0x01 SHALL be ignored.
REQ-026 Port B reads of 0x00 and 0x01 SHALL return CMD and STAT respectively.
REQ-027 If both ports write the same general address in one cycle, port A data SHALL win.
REQ-028 Writes by both ports to different addresses in the same cycle SHALL both complete.
REQ-029 Address arithmetic SHALL be modulo 64; there is no out-of-range condition.

Reset
REQ-030 When rst_n=0 at a clock edge, CMD and STAT SHALL be cleared to 0, so command = 0 from the following cycle.
REQ-031 Writes on both ports SHALL be ignored during reset.
REQ-032 General RAM contents SHALL NOT be reset; they retain prior values and are undefined after power-up.
REQ-033 Reset asserted mid-pulse SHALL clear CMD immediately at that edge.

Structure
REQ-034 A shared package SHALL hold: DATA_MSB=255, ADDR_MSB=5, CMD_ADDR=0x00, STAT_ADDR=0x01, RAM_BASE=0x02, and command codes CMD_IDLE=0 and CMD_START=2.
REQ-035 One sub-module, dpram_64x256, SHALL implement the 64-word dual-port array (two write ports, two asynchronous read ports, port A priority).
REQ-036 The top SHALL add the CMD/STAT decode and read-mux around dpram_64x256.

Verification
REQ-037 Port A writes 0xABCD to 0x15, then port B reads 0x15 -> b_data_out = 0xABCD combinationally in the cycle after the write.
REQ-038 Port A writes 2 to 0x00 -> command = 2 for exactly one cycle, then 0; a port A read of 0x00 afterwards returns 0.
REQ-039 Drive status = 0x5 -> a read of 0x01 returns 0x5 one cycle later; a port A write of 0xFF to 0x01 leaves STAT at 0x5.
REQ-040 Same-cycle writes to 0x20, port A data 0x1 and port B data 0x2 -> 0x20 reads 0x1.
REQ-041 Same-cycle read and write of 0x30 (old value 0x7, new value 0x9) -> read returns 0x7 that cycle and 0x9 the next.
REQ-042 Write 2 to CMD, then drive rst_n=0 in the following cycle -> command = 0 after that edge, STAT = 0, and RAM word 0x15 is unchanged.
